motion_delta_extractor: RTL
===========================

# motion_delta_extractor

Front end of the gesture path: turns a stream of tracked object positions into one movement vector per gesture. It records the start position when an object appears and follows it until the object leaves or a sample cap is reached. It then emits a single signed delta_x/delta_y pulse, which feeds the gesture classifier's delta input. Short or small movements are dropped, so the classifier only sees deliberate gestures.

## Interface
- DATA_BITS, 16: width of signed delta outputs; must be > COORD_BITS
- COORD_BITS, 10: width of unsigned input coordinates
- MIN_SAMPLES, 4: minimum present samples for a valid gesture
- MAX_SAMPLES, 64: sample cap; forces emission
- MIN_DIST, 16: minimum |dx|+|dy| for emission

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  one clock; reset is asynchronous and active-low
- pos_valid  in  1  sample strobe; other pos_* inputs are sampled only when high
- pos_present  in  1  object detected in this sample
- pos_x  in  COORD_BITS  unsigned x, grows rightward
- pos_y  in  COORD_BITS  unsigned y, grows downward (screen coordinates)
- delta_valid  out  1  one-cycle pulse, delta outputs valid
- delta_x  out  DATA_BITS  signed, last_x − start_x (right positive)
- delta_y  out  DATA_BITS  signed, start_y − last_y (up positive)
- busy  out  1  high in TRACK or HOLDOFF

## Operation
- The FSM has three states: IDLE, TRACK and HOLDOFF.
- IDLE: a sample with pos_valid=1 and pos_present=1 latches start_x/start_y and last_x/last_y from the inputs, sets count=1, and moves to TRACK.
- TRACK, present sample (pos_valid=1, pos_present=1): updates last_x/last_y and increments count.
  - If count reaches MAX_SAMPLES, the block evaluates the gesture and moves to HOLDOFF.
- TRACK, absent sample (pos_valid=1, pos_present=0): the block evaluates the gesture and moves to IDLE.
  - The absent sample's coordinates are ignored.
- Evaluation:
  - Coordinates are zero-extended to DATA_BITS and the differences computed in DATA_BITS signed arithmetic. No overflow is possible given DATA_BITS > COORD_BITS.
  - The block emits only if count ≥ MIN_SAMPLES and |dx|+|dy| ≥ MIN_DIST. Otherwise the gesture is discarded silently.
- HOLDOFF: present samples are ignored. The first absent sample returns the FSM to IDLE without emission.
- Cycles with pos_valid=0 never change state or counters.
- count saturates at MAX_SAMPLES; its width is $clog2(MAX_SAMPLES+1).

## Timing
- Reset values (asynchronous, on rst_n low):
  - FSM in IDLE, count=0
  - delta_valid=0, delta_x=0, delta_y=0, busy=0
- Latency: delta_valid is registered at the same edge that samples the terminating pos_valid. It is high for exactly the following cycle.
- delta_x/delta_y hold their last emitted value until the next emission.
- There is no backpressure; the downstream classifier accepts every pulse.
- Back-to-back gestures:
  - A present sample arriving in the cycle right after an absent-terminated emission is accepted as a new start from IDLE.
  - After a MAX_SAMPLES emission, at least one absent sample is required before a new start.
- busy rises the cycle after the start sample and falls the cycle after the sample that returns the FSM to IDLE.
- Reset asserted mid-TRACK aborts the gesture with no emission.
  - If rst_n falls in the same cycle an emission pulse is high, delta_valid clears immediately.

## Configuration
- DELTA_DEADZONE_EN defined: at evaluation, the minor axis is zeroed when it is less than half the major axis.
  - If 2·|dx| < |dy|, delta_x is output as 0.
  - If 2·|dy| < |dx|, delta_y is output as 0.
  - The MIN_DIST check uses the unmodified values.
- DELTA_DEADZONE_EN undefined: raw dx/dy are output.
- The deadzone adds no latency in either build.

## Test plan
All scenarios use default parameters and macro undefined unless stated.

- Reset: hold rst_n=0 with random inputs -> delta_valid=0, delta_x=0, delta_y=0, busy=0 throughout.
- Upward swipe:
  - Stimulus: present samples (100,200), (100,180), (100,160), (100,140), then one absent sample.
  - Response: one delta_valid pulse the cycle after the absent sample, with delta_x=0, delta_y=+60.
  - busy falls one cycle after the absent sample.
- Rejection:
  - 3 present samples (50,50) to (90,50), then absent -> no pulse (count too low).
  - 5 present samples moving 1 px right each, then absent -> no pulse (|dx|+|dy|=4 < 16).
- Sample cap:
  - Stimulus: 64 present samples with x=10..73, y=300.
  - Response: a pulse the cycle after the 64th sample, with delta_x=+63, delta_y=0.
  - Further present samples produce no pulse; an absent sample then a new present sample starts a new gesture.
- Deadzone: present samples (100,200), (104,185), (107,160), (110,140), then absent.
  - Undefined: delta_x=+10, delta_y=+60.
  - DELTA_DEADZONE_EN defined: delta_x=0, delta_y=+60.
- Reset mid-track: 3 present samples, pulse rst_n low for one cycle, then 1 present and 1 absent sample -> no pulse (new count=1). Gaps with pos_valid=0 between samples change nothing.

Source files
------------

// File: rtl/motion_delta_if.sv
// motion_delta_if: position-sample input stream and gesture delta output
// of the motion delta extractor. The master drives samples; the slave
// (the extractor) returns the delta pulse and busy.
interface motion_delta_if #(
    parameter int COORD_BITS = 10,
    parameter int DATA_BITS  = 16
);
    logic                        pos_valid;
    logic                        pos_present;
    logic        [COORD_BITS-1:0] pos_x;
    logic        [COORD_BITS-1:0] pos_y;
    logic                        delta_valid;
    logic signed [DATA_BITS-1:0]  delta_x;
    logic signed [DATA_BITS-1:0]  delta_y;
    logic                        busy;

    modport master (
        output pos_valid, pos_present, pos_x, pos_y,
        input  delta_valid, delta_x, delta_y, busy
    );

    modport slave (
        input  pos_valid, pos_present, pos_x, pos_y,
        output delta_valid, delta_x, delta_y, busy
    );
endinterface

// File: rtl/motion_delta_extractor.sv
// motion_delta_extractor: follows one tracked object from its first
// present sample until it disappears or MAX_SAMPLES is reached, then
// emits a single signed movement vector (x right-positive, y up-positive).
// Short or small gestures are dropped.
// Optional build macro DELTA_DEADZONE_EN: zero the minor axis when it is
// less than half of the major axis.
module motion_delta_extractor #(
    parameter int DATA_BITS   = 16,
    parameter int COORD_BITS  = 10,
    parameter int MIN_SAMPLES = 4,
    parameter int MAX_SAMPLES = 64,
    parameter int MIN_DIST    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    motion_delta_if.slave     bus
);
    localparam int CW = $clog2(MAX_SAMPLES + 1);
    // one extra bit so |dx|+|dy| and 2*|d| cannot wrap
    localparam int MW = DATA_BITS + 1;

    typedef enum logic [1:0] {IDLE, TRACK, HOLDOFF} state_t;

    state_t                      state_q, state_d;
    logic        [CW-1:0]         count_q, count_d;
    logic        [COORD_BITS-1:0] start_x_q, start_x_d, start_y_q, start_y_d;
    logic        [COORD_BITS-1:0] last_x_q, last_x_d, last_y_q, last_y_d;
    logic                        delta_valid_q, delta_valid_d;
    logic signed [DATA_BITS-1:0]  delta_x_q, delta_x_d, delta_y_q, delta_y_d;

    logic        [COORD_BITS-1:0] eval_x, eval_y;
    logic        [CW-1:0]         eval_count;
    logic signed [DATA_BITS-1:0]  dx, dy, out_dx, out_dy;
    logic        [MW-1:0]         adx, ady;
    logic                        gesture_ok;
    logic                        evaluate;

    function automatic logic signed [DATA_BITS-1:0] zext(input logic [COORD_BITS-1:0] c);
        return $signed({{(DATA_BITS - COORD_BITS){1'b0}}, c});
    endfunction

    function automatic logic [MW-1:0] abs_ext(input logic signed [DATA_BITS-1:0] v);
        logic signed [MW-1:0] w;
        w = {v[DATA_BITS-1], v};
        if (w < 0) w = -w;
        return w;
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c >= CW'(MAX_SAMPLES)) ? c : c + CW'(1);
    endfunction

    // Gesture evaluation datapath: a present sample contributes its own
    // coordinates, an absent one uses the last present position.
    always_comb begin
        eval_x     = bus.pos_present ? bus.pos_x : last_x_q;
        eval_y     = bus.pos_present ? bus.pos_y : last_y_q;
        eval_count = bus.pos_present ? sat_inc(count_q) : count_q;
        dx         = zext(eval_x) - zext(start_x_q);
        dy         = zext(start_y_q) - zext(eval_y);
        adx        = abs_ext(dx);
        ady        = abs_ext(dy);
        gesture_ok = (eval_count >= CW'(MIN_SAMPLES)) && ((adx + ady) >= MW'(MIN_DIST));
        out_dx     = dx;
        out_dy     = dy;
`ifdef DELTA_DEADZONE_EN
        if ((adx << 1) < ady) out_dx = '0;
        if ((ady << 1) < adx) out_dy = '0;
`endif
    end

    // Next-state and output logic; pos_valid=0 leaves everything untouched.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        start_x_d     = start_x_q;
        start_y_d     = start_y_q;
        last_x_d      = last_x_q;
        last_y_d      = last_y_q;
        delta_valid_d = 1'b0;
        delta_x_d     = delta_x_q;
        delta_y_d     = delta_y_q;
        evaluate      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.pos_valid && bus.pos_present) begin
                    start_x_d = bus.pos_x;
                    start_y_d = bus.pos_y;
                    last_x_d  = bus.pos_x;
                    last_y_d  = bus.pos_y;
                    count_d   = CW'(1);
                    state_d   = TRACK;
                end
            end
            TRACK: begin
                if (bus.pos_valid) begin
                    if (bus.pos_present) begin
                        last_x_d = bus.pos_x;
                        last_y_d = bus.pos_y;
                        count_d  = eval_count;
                        if (eval_count == CW'(MAX_SAMPLES)) begin
                            evaluate = 1'b1;
                            state_d  = HOLDOFF;
                        end
                    end else begin
                        evaluate = 1'b1;
                        count_d  = '0;
                        state_d  = IDLE;
                    end
                end
            end
            HOLDOFF: begin
                if (bus.pos_valid && !bus.pos_present) begin
                    count_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (evaluate && gesture_ok) begin
            delta_valid_d = 1'b1;
            delta_x_d     = out_dx;
            delta_y_d     = out_dy;
        end
    end

    // Control and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            count_q       <= '0;
            delta_valid_q <= 1'b0;
            delta_x_q     <= '0;
            delta_y_q     <= '0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            delta_valid_q <= delta_valid_d;
            delta_x_q     <= delta_x_d;
            delta_y_q     <= delta_y_d;
        end
    end

    // Coordinate registers; always written at a start sample before use.
    always_ff @(posedge clk) begin
        start_x_q <= start_x_d;
        start_y_q <= start_y_d;
        last_x_q  <= last_x_d;
        last_y_q  <= last_y_d;
    end

    assign bus.delta_valid = delta_valid_q;
    assign bus.delta_x     = delta_x_q;
    assign bus.delta_y     = delta_y_q;
    assign bus.busy        = (state_q != IDLE);
endmodule
